// File: rtl/lsu_dmem_initiator_pkg.sv
// ---------------------------------------------------------------------------
// lsu_dmem_initiator_pkg
// Shared definitions for the load/store data-memory initiator:
//   - XLEN         data width (only 32 is supported)
//   - SZ_*         request size encodings (same encoding as lwhb/swhb)
//   - lsu_state_e  initiator FSM state encoding
//   - helpers      byte-mask, lane strobe/data steering, word-crossing test
// ---------------------------------------------------------------------------
package lsu_dmem_initiator_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] SZ_ILL = 2'b00;
  localparam logic [1:0] SZ_B   = 2'b01;
  localparam logic [1:0] SZ_H   = 2'b10;
  localparam logic [1:0] SZ_W   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ACC0 = 2'b01,
    ST_ACC1 = 2'b10,
    ST_RESP = 2'b11
  } lsu_state_e;

  // Byte mask of an access before it is shifted into its lanes.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    logic [3:0] m;
    case (size)
      SZ_B:    m = 4'b0001;
      SZ_H:    m = 4'b0011;
      SZ_W:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Number of bytes touched by an access.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SZ_B:    n = 3'd1;
      SZ_H:    n = 3'd2;
      SZ_W:    n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  // Strobes over two consecutive words: [3:0] first word, [7:4] second word.
  function automatic logic [7:0] lane_strobe(input logic [1:0] size, input logic [1:0] off);
    return {4'b0000, size_mask(size)} << off;
  endfunction

  // Write data over two consecutive words: [31:0] first word, [63:32] second.
  function automatic logic [63:0] lane_data(input logic [31:0] wdata, input logic [1:0] off);
    return {32'h0000_0000, wdata} << {off, 3'b000};
  endfunction

  // An access crosses a word boundary when its last byte lies past lane 3.
  function automatic logic crosses_word(input logic [1:0] off, input logic [1:0] size);
    return ({1'b0, off} + size_bytes(size)) > 3'd4;
  endfunction

endpackage

// File: rtl/lsu_dmem_initiator_load_align.sv
// ---------------------------------------------------------------------------
// lsu_load_align
// Combinational load-result alignment: shifts the two-word window {hi,lo}
// right by the byte offset and sign/zero-extends the byte or half result.
// Ports:
//   data   in  64  {hi, lo} memory words (hi = 0 when the access is not split)
//   off    in  2   byte offset of the access within the first word
//   size   in  2   SZ_B / SZ_H / SZ_W
//   lu     in  1   zero-extend when 1, sign-extend when 0
//   result out 32  extended load data (0 for an illegal size)
// ---------------------------------------------------------------------------
module lsu_load_align
  import lsu_dmem_initiator_pkg::*;
(
  input  logic [63:0] data,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        lu,
  output logic [31:0] result
);

  logic [31:0] r;

  // Byte-shift the window, then extend according to size and lu.
  always_comb begin
    r = 32'(data >> {off, 3'b000});
    case (size)
      SZ_B: begin
        if (lu) begin
          result = {24'h00_0000, r[7:0]};
        end else begin
          result = {{24{r[7]}}, r[7:0]};
        end
      end
      SZ_H: begin
        if (lu) begin
          result = {16'h0000, r[15:0]};
        end else begin
          result = {{16{r[15]}}, r[15:0]};
        end
      end
      SZ_W:    result = r;
      default: result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_initiator.sv
// ---------------------------------------------------------------------------
// lsu_dmem_initiator
// Load/store initiator between the MEM stage and a word-wide data memory.
// One request at a time; byte/half/word accesses are steered onto byte lanes
// and an access that crosses a word boundary is split into two word accesses.
// All outputs are registered: the next-state logic also computes the next
// value of every output, so the memory port is stable for a whole state.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   -> a word-crossing access returns resp_err=1 without touching memory
//   undefined -> a word-crossing access is split into two accesses
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only when idle)
//   req_we/addr/size/lu/wdata  request fields
//   resp_valid/resp_ready response handshake
//   resp_rdata/resp_err   extended load data (0 for stores) / illegal access
//   mem_addr/we/wstrb/wdata  memory word port, mem_rdata combinational read
// ---------------------------------------------------------------------------
module lsu_dmem_initiator
  import lsu_dmem_initiator_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int MEM_AW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_lu,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic [3:0]        mem_wstrb,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata
);

  lsu_state_e state, state_n;

  logic [1:0]          off_lat, size_lat;
  logic                we_lat, lu_lat;
  logic [XLEN-1:0]     wdata_lat, lo, lo_n;
  logic                latch_req;

  logic                req_ready_n, resp_valid_n, resp_err_n, mem_we_n;
  logic [XLEN-1:0]     resp_rdata_n, mem_wdata_n;
  logic [MEM_AW-1:0]   mem_addr_n;
  logic [3:0]          mem_wstrb_n;

  logic [1:0]          lane_off, lane_size;
  logic [XLEN-1:0]     lane_wdata;
  logic [7:0]          lane_s;
  logic [2*XLEN-1:0]   lane_d;

  logic [2*XLEN-1:0]   align_in;
  logic [XLEN-1:0]     align_out;

  // Upper byte-address bits beyond the memory size do not select anything.
  logic                addr_unused;
  assign addr_unused = ^req_addr[ADDR_W-1:MEM_AW+2];

  // Lane steering: in IDLE the first access is prepared from the incoming
  // request, afterwards the second access is prepared from the latched one.
  always_comb begin
    if (state == ST_IDLE) begin
      lane_off   = req_addr[1:0];
      lane_size  = req_size;
      lane_wdata = req_wdata;
    end else begin
      lane_off   = off_lat;
      lane_size  = size_lat;
      lane_wdata = wdata_lat;
    end
    lane_s = lane_strobe(lane_size, lane_off);
    lane_d = lane_data(lane_wdata, lane_off);
  end

  // Load window: the word being read now is the newest one, so it is taken
  // straight from mem_rdata rather than from the lo register.
  always_comb begin
    if (state == ST_ACC1) begin
      align_in = {mem_rdata, lo};
    end else begin
      align_in = {{XLEN{1'b0}}, mem_rdata};
    end
  end

  lsu_load_align u_align (
    .data   (align_in),
    .off    (off_lat),
    .size   (size_lat),
    .lu     (lu_lat),
    .result (align_out)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_n      = state;
    latch_req    = 1'b0;
    lo_n         = lo;
    resp_valid_n = resp_valid;
    resp_rdata_n = resp_rdata;
    resp_err_n   = resp_err;
    mem_addr_n   = mem_addr;
    mem_we_n     = 1'b0;
    mem_wstrb_n  = 4'b0000;
    mem_wdata_n  = mem_wdata;

    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          latch_req = 1'b1;
          if (req_size == SZ_ILL) begin
            state_n      = ST_RESP;
            resp_valid_n = 1'b1;
            resp_err_n   = 1'b1;
            resp_rdata_n = {XLEN{1'b0}};
`ifdef LSU_MISALIGN_TRAP_EN
          end else if (crosses_word(req_addr[1:0], req_size)) begin
            state_n      = ST_RESP;
            resp_valid_n = 1'b1;
            resp_err_n   = 1'b1;
            resp_rdata_n = {XLEN{1'b0}};
`endif
          end else begin
            state_n     = ST_ACC0;
            mem_addr_n  = req_addr[MEM_AW+1:2];
            mem_we_n    = req_we;
            mem_wstrb_n = lane_s[3:0];
            mem_wdata_n = lane_d[XLEN-1:0];
          end
        end else begin
          state_n = ST_IDLE;
        end
      end

      ST_ACC0: begin
        lo_n = mem_rdata;
        if (crosses_word(off_lat, size_lat)) begin
          // Second word index wraps naturally at the MEM_AW width.
          state_n     = ST_ACC1;
          mem_addr_n  = mem_addr + MEM_AW'(1);
          mem_we_n    = we_lat;
          mem_wstrb_n = lane_s[7:4];
          mem_wdata_n = lane_d[2*XLEN-1:XLEN];
        end else begin
          state_n      = ST_RESP;
          resp_valid_n = 1'b1;
          resp_err_n   = 1'b0;
          if (we_lat) begin
            resp_rdata_n = {XLEN{1'b0}};
          end else begin
            resp_rdata_n = align_out;
          end
        end
      end

      ST_ACC1: begin
        state_n      = ST_RESP;
        resp_valid_n = 1'b1;
        resp_err_n   = 1'b0;
        if (we_lat) begin
          resp_rdata_n = {XLEN{1'b0}};
        end else begin
          resp_rdata_n = align_out;
        end
      end

      ST_RESP: begin
        if (resp_ready) begin
          state_n      = ST_IDLE;
          resp_valid_n = 1'b0;
        end else begin
          state_n = ST_RESP;
        end
      end

      default: begin
        state_n      = ST_IDLE;
        resp_valid_n = 1'b0;
      end
    endcase

    req_ready_n = (state_n == ST_IDLE);
  end

  // State, request latches and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      off_lat    <= 2'b00;
      size_lat   <= 2'b00;
      we_lat     <= 1'b0;
      lu_lat     <= 1'b0;
      wdata_lat  <= {XLEN{1'b0}};
      lo         <= {XLEN{1'b0}};
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= {XLEN{1'b0}};
      resp_err   <= 1'b0;
      mem_addr   <= {MEM_AW{1'b0}};
      mem_we     <= 1'b0;
      mem_wstrb  <= 4'b0000;
      mem_wdata  <= {XLEN{1'b0}};
    end else begin
      state      <= state_n;
      lo         <= lo_n;
      req_ready  <= req_ready_n;
      resp_valid <= resp_valid_n;
      resp_rdata <= resp_rdata_n;
      resp_err   <= resp_err_n;
      mem_addr   <= mem_addr_n;
      mem_we     <= mem_we_n;
      mem_wstrb  <= mem_wstrb_n;
      mem_wdata  <= mem_wdata_n;
      if (latch_req) begin
        off_lat   <= req_addr[1:0];
        size_lat  <= req_size;
        we_lat    <= req_we;
        lu_lat    <= req_lu;
        wdata_lat <= req_wdata;
      end
    end
  end

endmodule

// File: tb/tb_lsu_dmem_initiator.sv
// ---------------------------------------------------------------------------
// tb_lsu_dmem_initiator
// Directed bench for lsu_dmem_initiator with a behavioural 256-word memory.
// The driver pushes expected responses and expected memory writes into
// queues; a negedge monitor pops and compares them as the DUT presents them.
// ---------------------------------------------------------------------------
module tb_lsu_dmem_initiator;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_lu;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [256];

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          lat;
  } resp_t;

  typedef struct {
    logic [7:0]  a;
    logic [3:0]  s;
    logic [31:0] d;
  } wr_t;

  resp_t exp_q[$];
  wr_t   wr_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc = 0;
  logic prev_valid = 1'b0;

  lsu_dmem_initiator dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_size   (req_size),
    .req_lu     (req_lu),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  // Behavioural memory: strobed byte writes on the rising edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_wstrb[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got event want none", name);
  endtask

  // Monitor: latency, response data and memory writes against the queues.
  always @(negedge clk) begin : monitor
    resp_t r;
    wr_t   w;
    if (!reset && req_valid && req_ready) acc_cyc = cyc;
    if (resp_valid && !prev_valid) begin
      if (exp_q.size() == 0) fail_now("unexpected_resp");
      else chk("latency", 64'(cyc - acc_cyc), 64'(exp_q[0].lat));
    end
    if (resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_handshake");
      end else begin
        r = exp_q.pop_front();
        chk("resp_rdata", 64'(resp_rdata), 64'(r.rd));
        chk("resp_err", 64'(resp_err), 64'(r.err));
      end
    end
    prev_valid = resp_valid;
    if (mem_we) begin
      if (wr_q.size() == 0) begin
        fail_now("unexpected_mem_we");
      end else begin
        w = wr_q.pop_front();
        chk("mem_addr", 64'(mem_addr), 64'(w.a));
        chk("mem_wstrb", 64'(mem_wstrb), 64'(w.s));
        chk("mem_wdata", 64'(mem_wdata), 64'(w.d));
      end
    end
  end

  task automatic exp_wr(input logic [7:0] a, input logic [3:0] s, input logic [31:0] d);
    wr_t w;
    w.a = a; w.s = s; w.d = d;
    wr_q.push_back(w);
  endtask

  // Issue one request and complete its response; called at posedge+1.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic lu, input logic [31:0] wdata, input logic [31:0] exp_rd,
                       input logic exp_err, input int exp_lat, input int stall,
                       input bit hold_valid);
    resp_t r;
    int n;
    r.rd = exp_rd; r.err = exp_err; r.lat = exp_lat;
    exp_q.push_back(r);
    req_we = we; req_addr = addr; req_size = size; req_lu = lu; req_wdata = wdata;
    req_valid = 1'b1;
    resp_ready = (stall == 0);
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("req_ready_idle", 64'(req_ready), 64'(1));
    @(posedge clk); #1;
    if (hold_valid) begin
      // Busy-time request with different fields must not be latched.
      req_we = 1'b1; req_addr = 32'h0000_0100; req_size = 2'b11; req_wdata = 32'h1234_5678;
    end else begin
      req_valid = 1'b0;
    end
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("resp_arrives", 64'(resp_valid), 64'(1));
    for (int i = 0; i < stall; i++) begin
      chk("stall_valid", 64'(resp_valid), 64'(1));
      chk("stall_rdata", 64'(resp_rdata), 64'(exp_rd));
      chk("stall_err", 64'(resp_err), 64'(exp_err));
      chk("stall_req_ready", 64'(req_ready), 64'(0));
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    chk("post_resp_valid", 64'(resp_valid), 64'(0));
    chk("post_req_ready", 64'(req_ready), 64'(1));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0000;
    mem[255] = 32'h1122_3344;
    mem[0]   = 32'h5566_7788;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
    req_size = 2'b00; req_lu = 1'b0; req_wdata = 32'h0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_resp_rdata", 64'(resp_rdata), 64'(0));
    chk("rst_resp_err", 64'(resp_err), 64'(0));
    chk("rst_mem_we", 64'(mem_we), 64'(0));
    chk("rst_mem_wstrb", 64'(mem_wstrb), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    // Word store/load at 0x10 (index 4).
    exp_wr(8'd4, 4'b1111, 32'hDEAD_BEEF);
    issue(1'b1, 32'h10, 2'b11, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 0, 1'b0);
    issue(1'b0, 32'h10, 2'b11, 1'b0, 32'h0,        32'hDEAD_BEEF, 1'b0, 2, 0, 1'b0);

    // Byte store at 0x13 then signed/unsigned byte loads.
    exp_wr(8'd4, 4'b1000, 32'h8000_0000);
    issue(1'b1, 32'h13, 2'b01, 1'b0, 32'h0000_0080, 32'h0, 1'b0, 2, 0, 1'b0);
    issue(1'b0, 32'h13, 2'b01, 1'b0, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 0, 1'b0);
    issue(1'b0, 32'h13, 2'b01, 1'b1, 32'h0, 32'h0000_0080, 1'b0, 2, 0, 1'b1);
    issue(1'b0, 32'h10, 2'b11, 1'b0, 32'h0, 32'h80AD_BEEF, 1'b0, 2, 1, 1'b0);

    // Aligned halves inside word 4.
    issue(1'b0, 32'h12, 2'b10, 1'b1, 32'h0, 32'h0000_80AD, 1'b0, 2, 0, 1'b0);
    issue(1'b0, 32'h11, 2'b10, 1'b0, 32'h0, 32'hFFFF_ADBE, 1'b0, 2, 0, 1'b0);

    // Split half store at 0x0B and split half load back.
    exp_wr(8'd2, 4'b1000, 32'hB600_0000);
    exp_wr(8'd3, 4'b0001, 32'h0000_00A5);
    issue(1'b1, 32'h0B, 2'b10, 1'b0, 32'h0000_A5B6, 32'h0, 1'b0, 3, 0, 1'b0);
    issue(1'b0, 32'h0B, 2'b10, 1'b0, 32'h0, 32'hFFFF_A5B6, 1'b0, 3, 0, 1'b0);

    // Split word load wrapping from index 255 to index 0.
    issue(1'b0, 32'h3FE, 2'b11, 1'b0, 32'h0, 32'h7788_1122, 1'b0, 3, 0, 1'b0);

    // Illegal size: error after one cycle, held stable while stalled.
    issue(1'b0, 32'h40, 2'b00, 1'b0, 32'h0, 32'h0, 1'b1, 1, 3, 1'b0);
    issue(1'b1, 32'h44, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 0, 1'b0);

    // Reset during the first access of a split word store at 0x21.
    exp_wr(8'd8, 4'b1110, 32'hFEF0_0D00);
    req_we = 1'b1; req_addr = 32'h21; req_size = 2'b11; req_lu = 1'b0;
    req_wdata = 32'hCAFE_F00D; req_valid = 1'b1; resp_ready = 1'b0;
    chk("rst_test_ready", 64'(req_ready), 64'(1));
    @(posedge clk); #1;
    chk("rst_test_acc0_we", 64'(mem_we), 64'(1));
    reset = 1'b1; req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("after_rst_req_ready", 64'(req_ready), 64'(1));
    chk("after_rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("after_rst_mem_we", 64'(mem_we), 64'(0));
    repeat (4) @(posedge clk);
    #1;
    issue(1'b0, 32'h20, 2'b11, 1'b0, 32'h0, 32'hFEF0_0D00, 1'b0, 2, 0, 1'b0);
    issue(1'b0, 32'h24, 2'b11, 1'b0, 32'h0, 32'h0000_0000, 1'b0, 2, 0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("exp_q_drained", 64'(exp_q.size()), 64'(0));
    chk("wr_q_drained", 64'(wr_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
